// File: rtl/alu_program_sequencer.sv
// Program sequencer for the BreadBoard ALU/accumulator: issues one stored {op_code, operand}
// instruction at a time, with inputA settled before each single execute cycle.
module alu_program_sequencer #(
    parameter int SETTLE     = 1,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [19:0]           prog_data,
    input  logic                  start,
    output logic [3:0]            op_code,
    output logic [15:0]           inputA,
    input  logic [31:0]           alu_R,
    input  logic                  alu_error,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           result,
    output logic                  err_ovf,
    output logic                  err_divzero,
    output logic [DEPTH_LOG2-1:0] pc,
    output logic [DEPTH_LOG2:0]   instr_count
);

    localparam int DEPTH = 2**DEPTH_LOG2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_MOD   = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_RESET = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_NOOP  = 4'd13;
    localparam logic [3:0] OP_HALT  = 4'd14;

    localparam logic [DEPTH_LOG2-1:0] PC_MAX      = '1;
    localparam logic [DEPTH_LOG2-1:0] PC_ONE      = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE     = 1;
    localparam logic [2:0]            SETTLE_LAST = 3'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    logic [19:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            op_code_q, op_code_d;
    logic [15:0]           inputA_q, inputA_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [31:0]           result_q, result_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_divzero_q, err_divzero_d;
    logic [DEPTH_LOG2-1:0] pc_q, pc_d;
    logic [DEPTH_LOG2:0]   instr_count_q, instr_count_d;
    logic [15:0]           acc_low_q, acc_low_d;
    logic [2:0]            settle_cnt_q, settle_cnt_d;

    logic [19:0] cur_instr;
    logic [3:0]  cur_op;

    // Memory is only written in IDLE, so the instruction under pc is stable for a whole run.
    assign cur_instr = mem[pc_q];
    assign cur_op    = cur_instr[19:16];

    always_ff @(posedge clk) begin
        if (prog_we && state_q == IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_code_d     = OP_NOOP;
        inputA_d      = inputA_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        err_ovf_d     = err_ovf_q;
        err_divzero_d = err_divzero_q;
        pc_d          = pc_q;
        instr_count_d = instr_count_q;
        acc_low_d     = acc_low_q;
        settle_cnt_d  = settle_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    result_d      = '0;
                    err_ovf_d     = 1'b0;
                    err_divzero_d = 1'b0;
                    instr_count_d = '0;
                    pc_d          = '0;
                    acc_low_d     = '0;
                    settle_cnt_d  = '0;
                    busy_d        = 1'b1;
                    state_d       = FETCH;
                end
            end
            FETCH: begin
                if (settle_cnt_q == 3'd0 && cur_op == OP_HALT) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    inputA_d = cur_instr[15:0];
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = '0;
                        op_code_d    = cur_op;
                        state_d      = EXEC;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 3'd1;
                    end
                end
            end
            EXEC: begin
                result_d      = alu_R;
                instr_count_d = instr_count_q + CNT_ONE;
                err_ovf_d     = err_ovf_q | (alu_error & (cur_op == OP_ADD || cur_op == OP_SUB));
                // acc_low mirrors the ALU's inputB, which is what divides/modulos by.
                err_divzero_d = err_divzero_q |
                                ((cur_op == OP_MOD || cur_op == OP_DIV) && acc_low_q == 16'd0);
                acc_low_d     = (cur_op == OP_RESET) ? 16'd0 : alu_R[15:0];
                if (pc_q == PC_MAX) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = FETCH;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_code_q     <= OP_NOOP;
            inputA_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            err_ovf_q     <= 1'b0;
            err_divzero_q <= 1'b0;
            pc_q          <= '0;
            instr_count_q <= '0;
            acc_low_q     <= '0;
            settle_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            op_code_q     <= op_code_d;
            inputA_q      <= inputA_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            err_ovf_q     <= err_ovf_d;
            err_divzero_q <= err_divzero_d;
            pc_q          <= pc_d;
            instr_count_q <= instr_count_d;
            acc_low_q     <= acc_low_d;
            settle_cnt_q  <= settle_cnt_d;
        end
    end

    assign op_code     = op_code_q;
    assign inputA      = inputA_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign err_ovf     = err_ovf_q;
    assign err_divzero = err_divzero_q;
    assign pc          = pc_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Bench for alu_program_sequencer: a behavioural ALU + accumulator closes the loop, and each
// run's expected outcome is queued at start and compared when done pulses.
module tb_alu_program_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic [3:0]  op_code;
    logic [15:0] inputA;
    logic [31:0] alu_R;
    logic        alu_error;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err_ovf;
    logic        err_divzero;
    logic [3:0]  pc;
    logic [4:0]  instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_program_sequencer #(.SETTLE(1), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .op_code(op_code), .inputA(inputA),
        .alu_R(alu_R), .alu_error(alu_error), .busy(busy), .done(done), .result(result),
        .err_ovf(err_ovf), .err_divzero(err_divzero), .pc(pc), .instr_count(instr_count)
    );

    // ALU model: inputB is accumulator[15:0]; the accumulator captures R every edge.
    logic [31:0] acc = 32'd0;
    logic [16:0] wide;
    always_comb begin
        alu_R     = acc;
        alu_error = 1'b0;
        wide      = 17'd0;
        case (op_code)
            4'd0: begin
                wide      = {1'b0, inputA} + {1'b0, acc[15:0]};
                alu_R     = {16'h0, wide[15:0]};
                alu_error = wide[16];
            end
            4'd1: begin
                if (acc[15:0] == 16'd0) begin alu_R = 32'hFFFF_FFFF; alu_error = 1'b1; end
                else alu_R = {16'h0, inputA % acc[15:0]};
            end
            4'd2: begin
                if (acc[15:0] == 16'd0) begin alu_R = 32'hFFFF_FFFF; alu_error = 1'b1; end
                else alu_R = {16'h0, inputA / acc[15:0]};
            end
            4'd3:  alu_R = 32'd0;
            4'd4:  alu_R = {16'h0, inputA} * {16'h0, acc[15:0]};
            4'd8: begin
                wide      = {1'b0, acc[15:0]} - {1'b0, inputA};
                alu_R     = {16'h0, wide[15:0]};
                alu_error = wide[16];
            end
            4'd15: alu_R = 32'hFFFF_FFFF;
            default: alu_R = acc;
        endcase
    end
    always @(posedge clk) acc <= alu_R;

    typedef struct packed {
        logic [15:0][19:0] prog;
        int                len;
        logic [31:0]       res;
        logic              ovf;
        logic              dz;
        int                cnt;
        int                lat;
        logic [3:0]        pc;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    vec_t exp_q [$];

    function automatic logic [19:0] ins(input logic [3:0] op, input logic [15:0] opnd);
        return {op, opnd};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_prog(input int idx);
        for (int i = 0; i < vecs[idx].len; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = vecs[idx].prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Start a run of vector idx; with disturb, write memory and pulse start while busy.
    task automatic run_prog(input int idx, input bit disturb);
        vec_t e;
        int   cyc;
        int   extra;
        exp_q.push_back(vecs[idx]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_rise", 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 200) begin
            if (disturb && cyc == 3) begin
                prog_we   = 1'b1;
                prog_addr = 4'd1;
                prog_data = ins(4'd0, 16'd100);
                start     = 1'b1;
            end else begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        prog_we = 1'b0;
        start   = 1'b0;
        e = exp_q.pop_front();
        if (cyc >= 200) begin
            check("done_timeout", 32'(cyc), 32'(e.lat));
        end else begin
            check("latency", 32'(cyc), 32'(e.lat));
            check("result", result, e.res);
            check("err_ovf", 32'(err_ovf), 32'(e.ovf));
            check("err_divzero", 32'(err_divzero), 32'(e.dz));
            check("instr_count", 32'(instr_count), 32'(e.cnt));
            check("pc", 32'(pc), 32'(e.pc));
            check("busy_at_done", 32'(busy), 32'd1);
            @(negedge clk);
            check("done_width", 32'(done), 32'd0);
            check("busy_fall", 32'(busy), 32'd0);
            check("result_hold", result, e.res);
            $display("run vec %0d: result %h ovf %0d dz %0d count %0d pc %0d latency %0d",
                     idx, result, err_ovf, err_divzero, instr_count, pc, cyc);
        end
        if (disturb) begin
            extra = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check("extra_done", 32'(extra), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op_code"}, 32'(op_code), 32'd13);
        check({tag, "_inputA"}, 32'(inputA), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
        check({tag, "_err_divzero"}, 32'(err_divzero), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_instr_count"}, 32'(instr_count), 32'd0);
    endtask

    initial begin
        int wait_cyc;

        for (int v = 0; v < NV; v++) vecs[v] = '0;
        vecs[0].prog[0] = ins(4'd3, 16'd0);
        vecs[0].prog[1] = ins(4'd0, 16'd6);
        vecs[0].prog[2] = ins(4'd0, 16'd6);
        vecs[0].prog[3] = ins(4'd4, 16'd3);
        vecs[0].prog[4] = ins(4'd14, 16'd0);
        vecs[0].len = 5; vecs[0].res = 32'd36; vecs[0].cnt = 4; vecs[0].lat = 10; vecs[0].pc = 4'd4;

        vecs[1].prog[0] = ins(4'd3, 16'd0);
        vecs[1].prog[1] = ins(4'd2, 16'd5);
        vecs[1].prog[2] = ins(4'd14, 16'd0);
        vecs[1].len = 3; vecs[1].res = 32'hFFFF_FFFF; vecs[1].dz = 1'b1;
        vecs[1].cnt = 2; vecs[1].lat = 6; vecs[1].pc = 4'd2;

        vecs[2].prog[0] = ins(4'd14, 16'd0);
        vecs[2].len = 1; vecs[2].res = 32'd0; vecs[2].cnt = 0; vecs[2].lat = 2; vecs[2].pc = 4'd0;

        vecs[3].prog[0] = ins(4'd15, 16'd0);
        vecs[3].prog[1] = ins(4'd0, 16'd1);
        vecs[3].prog[2] = ins(4'd14, 16'd0);
        vecs[3].len = 3; vecs[3].res = 32'd0; vecs[3].ovf = 1'b1;
        vecs[3].cnt = 2; vecs[3].lat = 6; vecs[3].pc = 4'd2;

        for (int i = 0; i < 16; i++) vecs[4].prog[i] = ins(4'd13, 16'(i));
        vecs[4].len = 16; vecs[4].res = 32'd0; vecs[4].cnt = 16; vecs[4].lat = 33; vecs[4].pc = 4'd15;

        vecs[5].prog[0] = ins(4'd3, 16'd0);
        vecs[5].prog[1] = ins(4'd0, 16'd7);
        vecs[5].prog[2] = ins(4'd1, 16'd3);
        vecs[5].prog[3] = ins(4'd8, 16'd1);
        vecs[5].prog[4] = ins(4'd14, 16'd0);
        vecs[5].len = 5; vecs[5].res = 32'd2; vecs[5].cnt = 4; vecs[5].lat = 10; vecs[5].pc = 4'd4;

        vecs[6].prog[0] = ins(4'd3, 16'd0);
        vecs[6].prog[1] = ins(4'd8, 16'd1);
        vecs[6].prog[2] = ins(4'd14, 16'd0);
        vecs[6].len = 3; vecs[6].res = 32'h0000_FFFF; vecs[6].ovf = 1'b1;
        vecs[6].cnt = 2; vecs[6].lat = 6; vecs[6].pc = 4'd2;

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 20'd0; start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            load_prog(v);
            run_prog(v, 1'b0);
        end

        // Writes and start while busy must be ignored; a plain re-run proves memory is intact.
        load_prog(0);
        run_prog(0, 1'b1);
        run_prog(0, 1'b0);

        // Abort mid-EXEC of the first ADD with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (op_code !== 4'd0 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("exec_seen", 32'(op_code), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_idle_done", 32'(done), 32'd0);
        end
        run_prog(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
